// File: rtl/param_updown_counter_mod_if.sv
// Control/status bundle for param_updown_counter_mod.
// prescale_div exists only when COUNTER_PRESCALE_EN is defined.
interface param_updown_counter_mod_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic             down;
    logic [1:0]       mode;
    logic [WIDTH-1:0] min_val;
    logic [WIDTH-1:0] max_val;
`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_div;
`endif
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             at_max;
    logic             at_min;
    logic             cfg_err;

    modport master (
        output clear, load, load_val, en, up, down, mode, min_val, max_val,
`ifdef COUNTER_PRESCALE_EN
        output prescale_div,
`endif
        input  count, tc, at_max, at_min, cfg_err
    );

    modport slave (
        input  clear, load, load_val, en, up, down, mode, min_val, max_val,
`ifdef COUNTER_PRESCALE_EN
        input  prescale_div,
`endif
        output count, tc, at_max, at_min, cfg_err
    );
endinterface

// File: rtl/param_updown_counter_mod.sv
// Programmable-bound up/down counter with wrap, saturate and one-shot end-of-range modes.
// Optional step prescaler enabled by defining COUNTER_PRESCALE_EN.
module param_updown_counter_mod #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input logic                          clk,
    input logic                          reset_n,
    param_updown_counter_mod_if.slave    bus
);
    typedef enum logic [0:0] {StRun, StDone} state_e;

    localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_d;
    logic             r_tc;
    logic             w_tc_d;

    logic w_cfg_err;
    logic w_at_max;
    logic w_at_min;
    logic w_at_bound;
    logic w_step_req;
    logic w_step;
    logic w_restart;

    assign w_cfg_err  = bus.min_val > bus.max_val;
    assign w_at_max   = r_count >= bus.max_val;
    assign w_at_min   = r_count <= bus.min_val;
    assign w_at_bound = bus.up ? w_at_max : w_at_min;
    assign w_restart  = bus.clear | bus.load;
    // up & down together cancel; config errors and DONE swallow the request
    assign w_step_req = bus.en & (bus.up ^ bus.down) & ~w_cfg_err & (r_state == StRun);

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] w_presc_d;

    assign w_step = w_step_req & (r_presc == bus.prescale_div);

    always_comb begin
        w_presc_d = r_presc;
        if (w_restart) begin
            w_presc_d = '0;
        end else if (w_step_req) begin
            w_presc_d = w_step ? '0 : r_presc + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else begin
            r_presc <= w_presc_d;
        end
    end
`else
    assign w_step = w_step_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StRun;
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
            r_tc    <= w_tc_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (w_restart) begin
            w_state_d = StRun;
        end else if (w_step && w_at_bound && (bus.mode == 2'b10)) begin
            w_state_d = StDone;
        end
    end

    always_comb begin
        w_count_d = r_count;
        w_tc_d    = 1'b0;
        if (bus.clear) begin
            w_count_d = bus.min_val;
        end else if (bus.load) begin
            w_count_d = bus.load_val;
        end else if (w_step) begin
            if (!w_at_bound) begin
                w_count_d = bus.up ? r_count + LP_ONE : r_count - LP_ONE;
            end else begin
                w_tc_d = 1'b1;
                case (bus.mode)
                    2'b01, 2'b10: w_count_d = r_count;
                    default:      w_count_d = bus.up ? bus.min_val : bus.max_val;
                endcase
            end
        end
    end

    assign bus.count   = r_count;
    assign bus.tc      = r_tc;
    assign bus.at_max  = w_at_max;
    assign bus.at_min  = w_at_min;
    assign bus.cfg_err = w_cfg_err;
endmodule
